rv_rr_arbiter: RTL and testbench
================================

Name: rv_rr_arbiter

Overview:
- N-to-1 round-robin arbiter that shares a single registered ready/valid pipeline stage between N_REQ upstream requesters.
- Each requester presents a valid/ready/data channel. The winner's data is captured into one output register and presented downstream together with the winner's index.
- Sits in front of a shared datapath stage so that several producers can feed one consumer without starvation.

Parameters:
- N_REQ, 4, number of requester channels (2..16).
- DATA_W, 16, payload width per channel.
- MAX_BURST, 4, maximum consecutive transfers granted to one requester when burst lock is compiled in (1..255).
- ID_W, derived as $clog2(N_REQ), width of the requester index; not user-set.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N_REQ  per-requester valid, bit i = requester i.
- in_data  input  N_REQ*DATA_W  per-requester payload, requester i at bits [i*DATA_W +: DATA_W].
- in_ready  output  N_REQ  per-requester ready; at most one bit high in any cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  payload of held beat.
- out_id  output  ID_W  index of requester that produced the held beat.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_id=0, rr pointer ptr=0, burst counter=0, lock=0.
- Reset mid-operation discards any held beat; no transfer completes in a cycle where reset is high.
- Stage-accept condition: accept = ~out_valid | out_ready, same as a single pipeline register.
- Arbitration (combinational): scan in_valid starting at index ptr, wrapping modulo N_REQ. The first set bit is the grant g.
  - No set bit: no grant.
  - in_ready[i] = accept & grant_valid & (i==g).
- Dependency rules:
  - in_ready may depend combinationally on in_valid.
  - Requesters must not make in_valid depend on in_ready.
  - A requester holding valid must keep its data stable until its ready is seen.
- Input transfer: occurs on a rising edge when in_valid[g] & in_ready[g]. On that edge:
  - out_data <= in_data[g]
  - out_id <= g
  - out_valid <= 1
  - ptr <= (g+1) mod N_REQ (no-lock build)
- Output transfer: occurs on a rising edge when out_valid & out_ready.
  - If no input transfer in the same cycle: out_valid <= 0, and data/id hold their last values.
  - If an input transfer occurs in the same cycle: the register is overwritten and out_valid stays 1 (full throughput, 1 beat/cycle).
- Stall: out_valid & ~out_ready leaves out_data, out_id and out_valid unchanged; all in_ready=0; ptr unchanged.
- Latency: 1 cycle from input transfer to out_valid.
- Idle: ptr is updated only on an input transfer.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,2,...,N_REQ-1,0 with no repeats.
- Wrap: a grant at index N_REQ-1 sets ptr=0.

Optional Feature:
- Macro: RV_RR_ARBITER_BURST_LOCK_EN.
- Defined:
  - After an input transfer from g, lock=1 and the burst counter increments. While lock=1, grant is forced to g (other requesters get in_ready=0), and ptr is not advanced.
  - Lock releases and ptr <= (g+1) mod N_REQ on whichever comes first:
    - the MAX_BURST-th consecutive transfer from g, or
    - an accept cycle in which in_valid[g]=0.
  - The release cycle falls back to normal RR arbitration from the new ptr in the same cycle.
  - The counter resets to 0 on release.
  - Lock is held across downstream stalls.
- Undefined: no lock or counter logic; ptr advances after every transfer; MAX_BURST unused.

Test Plan:
- Reset then idle: reset high for 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_id=0, in_ready=0 throughout.
- Single requester: in_valid=4'b0100, in_data[2]=16'hABCD, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=16'hABCD, out_id=2.
- Full contention, no lock: in_valid=4'b1111 constant, out_ready=1, data = requester index -> out_id sequence 0,1,2,3,0,1,... at one beat per cycle.
- Back-pressure: hold beat with out_id=1, out_ready=0 for 5 cycles while in_valid=4'b1111 -> out_data/out_id stable and in_ready=0. out_ready=1 -> next grant is 2.
- Wrap and skip: ptr=3, in_valid=4'b0010 -> grant 1 and ptr becomes 2. Then in_valid=4'b1001 -> grant 3, then 0.
- Burst lock (macro defined, MAX_BURST=4): in_valid=4'b0011 constant, out_ready=1 -> out_id 0,0,0,0,1,1,1,1,0. Dropping in_valid[1] after two beats from 1 releases the lock to 0.

Source files
------------

// File: rtl/rv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rv_rr_arbiter
//
// N-to-1 round-robin arbiter feeding one registered ready/valid stage. Several
// producers share a single downstream consumer. The winning requester's
// payload and index are captured into the output register. Grants rotate so
// that no continuously valid requester is starved.
//
// Ports:
//   clk        in   1             clock; all state changes on the rising edge
//   reset      in   1             synchronous, active-high reset
//   in_valid   in   N_REQ         per-requester valid (bit i = requester i)
//   in_data    in   N_REQ*DATA_W  per-requester payload, i at [i*DATA_W +: DATA_W]
//   in_ready   out  N_REQ         per-requester ready, at most one bit set
//   out_valid  out  1             output register holds a beat
//   out_data   out  DATA_W        payload of the held beat
//   out_id     out  ID_W          index of the requester that produced the beat
//   out_ready  in   1             downstream accepts the held beat
//
// Optional feature macro: RV_RR_ARBITER_BURST_LOCK_EN
//   Defined   : after a transfer, the winner keeps the grant for up to
//               MAX_BURST consecutive beats. The lock ends early on an accept
//               cycle where the winner is not valid.
//   Undefined : plain round-robin. The pointer advances after every
//               transfer, and MAX_BURST has no effect.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rv_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_WIDE  = (ID_W + 1)'(N_REQ);

  // Elaboration-time guard on the supported parameter ranges.
  if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_params
    $error("rv_rr_arbiter: N_REQ must be 2..16 and MAX_BURST 1..255");
  end

  // Successor of a requester index, wrapping at N_REQ-1. This also works
  // when N_REQ is not a power of two.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [ID_W-1:0]   out_id_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic [ID_W-1:0]   ptr_next;

`ifdef RV_RR_ARBITER_BURST_LOCK_EN
  localparam int             CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  logic              lock_reg;
  logic              lock_next;
  logic [ID_W-1:0]   lock_id_reg;
  logic [ID_W-1:0]   lock_id_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              release_idle;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic              xfer;
  logic [ID_W-1:0]   scan_start;
  logic [ID_W-1:0]   scan_idx [N_REQ];
  logic [N_REQ-1:0]  scan_hit;
  logic [DATA_W-1:0] in_data_arr [N_REQ];

  assign accept = ~out_valid_reg | out_ready;

`ifdef RV_RR_ARBITER_BURST_LOCK_EN
  // When the lock drops because the owner went idle, arbitration restarts
  // from the slot after the owner in the same cycle. So the scan already
  // begins there while the lock is held.
  assign scan_start   = lock_reg ? next_id(lock_id_reg) : ptr_reg;
  assign release_idle = lock_reg & accept & ~in_valid[lock_id_reg];
`else
  assign scan_start = ptr_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_chan
      logic [ID_W:0] sum;
      // Slot gi of the rotated scan order: (scan_start + gi) mod N_REQ.
      assign sum          = {1'b0, scan_start} + (ID_W + 1)'(gi);
      assign scan_idx[gi] = (sum >= N_WIDE) ? ID_W'(sum - N_WIDE) : sum[ID_W-1:0];
      assign scan_hit[gi] = in_valid[scan_idx[gi]];
      assign in_data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
      assign in_ready[gi]    = xfer & (grant_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    // Walk from the far end of the scan so the nearest hit wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (scan_hit[k]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx[k];
      end
    end
`ifdef RV_RR_ARBITER_BURST_LOCK_EN
    if (lock_reg && in_valid[lock_id_reg]) begin
      grant_valid = 1'b1;
      grant_id    = lock_id_reg;
    end
`endif
  end

  // The granted requester is valid by construction, so a grant during an
  // accept cycle is a completed handshake. Reset suppresses it.
  assign xfer = ~reset & accept & grant_valid;

  // ---------------------------------------------------------------------------
  // Pointer / lock next state
  // ---------------------------------------------------------------------------
`ifdef RV_RR_ARBITER_BURST_LOCK_EN
  always_comb begin
    ptr_next     = ptr_reg;
    lock_next    = lock_reg;
    lock_id_next = lock_id_reg;
    cnt_next     = cnt_reg;
    cnt_inc      = '0;
    if (release_idle) begin
      lock_next = 1'b0;
      cnt_next  = '0;
      ptr_next  = next_id(lock_id_reg);
    end
    if (xfer) begin
      // A beat continues the burst only if the lock survived this cycle.
      // Otherwise it is the first beat of a new burst.
      cnt_inc = (lock_next ? cnt_reg : '0) + 1'b1;
      if (cnt_inc == BURST_LAST) begin
        lock_next = 1'b0;
        cnt_next  = '0;
        ptr_next  = next_id(grant_id);
      end else begin
        lock_next    = 1'b1;
        lock_id_next = grant_id;
        cnt_next     = cnt_inc;
      end
    end
  end
`else
  always_comb begin
    ptr_next = ptr_reg;
    if (xfer) begin
      ptr_next = next_id(grant_id);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      ptr_reg       <= '0;
`ifdef RV_RR_ARBITER_BURST_LOCK_EN
      lock_reg      <= 1'b0;
      lock_id_reg   <= '0;
      cnt_reg       <= '0;
`endif
    end else begin
      ptr_reg <= ptr_next;
`ifdef RV_RR_ARBITER_BURST_LOCK_EN
      lock_reg    <= lock_next;
      lock_id_reg <= lock_id_next;
      cnt_reg     <= cnt_next;
`endif
      if (xfer) begin
        // An input beat overwrites the register even while the old beat
        // leaves, which gives one beat per cycle.
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data_arr[grant_id];
        out_id_reg    <= grant_id;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv_rr_arbiter
//
// Directed bench for rv_rr_arbiter (N_REQ=4, DATA_W=16, MAX_BURST=4).
//
// A behavioural model predicts the handshake and output register. It holds a
// rotating start pointer, an optional burst owner and the held beat. The model
// is compared against the DUT on every cycle. Hand-computed literal
// expectations along the directed scenarios pin the model.
//
// The bench tracks RV_RR_ARBITER_BURST_LOCK_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rv_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic [N-1:0]    in_valid  = '0;
  logic [N*DW-1:0] in_data   = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_ready = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_rr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit            started  = 1'b0;
  bit            m_valid  = 1'b0;
  logic [DW-1:0] m_data   = '0;
  int            m_id     = 0;
  int            m_ptr    = 0;
  bit            m_locked = 1'b0;
  int            m_owner  = 0;
  int            m_cnt    = 0;

  // Which requester must be handed the beat this cycle, or -1 for none.
  function automatic int model_grant(input logic [N-1:0] v);
    int start;
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    start = m_ptr;
`ifdef RV_RR_ARBITER_BURST_LOCK_EN
    if (m_locked && v[m_owner]) return m_owner;
    if (m_locked) start = (m_owner + 1) % N;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_update
    int g;
    g = model_grant(in_valid);
    started = 1'b1;
    if (reset) begin
      m_valid  = 1'b0;
      m_data   = '0;
      m_id     = 0;
      m_ptr    = 0;
      m_locked = 1'b0;
      m_owner  = 0;
      m_cnt    = 0;
    end else begin
`ifdef RV_RR_ARBITER_BURST_LOCK_EN
      if (m_locked && !in_valid[m_owner] && (!m_valid || out_ready)) begin
        m_locked = 1'b0;
        m_cnt    = 0;
        m_ptr    = (m_owner + 1) % N;
      end
`endif
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*DW +: DW];
        m_id    = g;
`ifdef RV_RR_ARBITER_BURST_LOCK_EN
        m_cnt = m_cnt + 1;
        if (m_cnt == MB) begin
          m_locked = 1'b0;
          m_cnt    = 0;
          m_ptr    = (g + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner  = g;
        end
`else
        m_ptr = (g + 1) % N;
`endif
        $display("xfer t=%0t id=%0d data=%h", $time, g, m_data);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin : compare
    int g;
    if (started) begin
      g = model_grant(in_valid);
      chk("cyc_in_ready",  32'(in_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_out_data",  32'(out_data),  32'(m_data));
      chk("cyc_out_id",    32'(out_id),    32'(m_id));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    in_data[i*DW +: DW] = d;
  endtask

  task automatic data_is_index();
    for (int i = 0; i < N; i++) set_data(i, DW'(i));
  endtask

`ifdef RV_RR_ARBITER_BURST_LOCK_EN
  int burst_seq [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
`endif

  initial begin : stimulus
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #4;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data",  32'(out_data),  32'd0);
    chk("reset_out_id",    32'(out_id),    32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd0);
    tick();

`ifndef RV_RR_ARBITER_BURST_LOCK_EN
    // Single requester.
    set_data(2, 16'hABCD);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #4;
    chk("single_in_ready", 32'(in_ready), 32'b0100);
    tick();
    in_valid = 4'b0000;
    #4;
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data",  32'(out_data),  32'hABCD);
    chk("single_out_id",    32'(out_id),    32'd2);
    tick();

    // Wrap and skip: ptr is now 3.
    in_valid = 4'b0010;
    #4;
    chk("wrap_grant1", 32'(in_ready), 32'b0010);
    tick();
    in_valid = 4'b1001;
    #4;
    chk("skip_grant3", 32'(in_ready), 32'b1000);
    chk("skip_out_id1", 32'(out_id), 32'd1);
    tick();
    #4;
    chk("skip_grant0", 32'(in_ready), 32'b0001);
    chk("skip_out_id3", 32'(out_id), 32'd3);
    tick();

    // Reset with a beat held: the beat is discarded and ptr returns to 0.
    data_is_index();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    reset     = 1'b1;
    #4;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;

    // Full contention: grants 0,1,2,3,0,1,... one per cycle.
    for (int k = 0; k < 10; k++) begin
      #4;
      chk("rr_in_ready", 32'(in_ready), 32'd1 << (k % 4));
      if (k == 0) begin
        chk("rr_out_valid0", 32'(out_valid), 32'd0);
        chk("rr_out_id0",    32'(out_id),    32'd0);
      end else begin
        chk("rr_out_valid", 32'(out_valid), 32'd1);
        chk("rr_out_id",    32'(out_id),    32'((k - 1) % 4));
        chk("rr_out_data",  32'(out_data),  32'((k - 1) % 4));
      end
      tick();
    end

    // Back-pressure with the beat from requester 1 held.
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #4;
      chk("stall_in_ready", 32'(in_ready),  32'd0);
      chk("stall_valid",    32'(out_valid), 32'd1);
      chk("stall_out_id",   32'(out_id),    32'd1);
      chk("stall_out_data", 32'(out_data),  32'd1);
      tick();
    end
    out_ready = 1'b1;
    #4;
    chk("resume_grant2", 32'(in_ready), 32'b0100);
    tick();
    in_valid = 4'b0000;
    #4;
    chk("resume_out_id", 32'(out_id), 32'd2);
    tick();
    #4;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    tick();
`else
    // Burst lock: 0x4, 1x4, 0x4, 1x2, then requester 1 drops.
    data_is_index();
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      #4;
      chk("burst_in_ready", 32'(in_ready), 32'd1 << burst_seq[k]);
      if (k > 0) chk("burst_out_id", 32'(out_id), 32'(burst_seq[k-1]));
      tick();
    end
    in_valid = 4'b0001;
    #4;
    chk("burst_release_to0", 32'(in_ready), 32'b0001);
    chk("burst_out_id_last", 32'(out_id), 32'd1);
    tick();
    in_valid = 4'b0000;
    #4;
    chk("burst_after_id", 32'(out_id), 32'd0);
    tick();
    #4;
    chk("burst_drain_valid", 32'(out_valid), 32'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
